// File: rtl/banco_pkg.sv
`default_nettype none
// ============================================================================
// banco_pkg: shared state encoding and default geometry for the register bank
// Rev 1.0
// ============================================================================
package banco_pkg;
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } banco_state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;
endpackage
`default_nettype wire

// File: rtl/banco_clear_fsm.sv
`default_nettype none
// ============================================================================
// banco_clear_fsm: sweeps every entry to zero after reset or clear request
// Rev 1.0
// ============================================================================
module banco_clear_fsm
  import banco_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear_req,
  output logic                     o_ready,
  output logic                     o_clr_we,
  output logic [$clog2(DEPTH)-1:0] o_clr_addr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] c_last = AW'(DEPTH - 1);

  banco_state_t  r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic          r_ready, w_ready_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    case (r_state)
      CLEAR: begin
        if (r_cnt == c_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_ready_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      IDLE: begin
        if (i_clear_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
          w_ready_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_cnt_nxt   = '0;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  assign o_ready    = r_ready;
  assign o_clr_we   = (r_state == CLEAR) && !rst;
  assign o_clr_addr = r_cnt;
endmodule
`default_nettype wire

// File: rtl/banco_registros_param.sv
`default_nettype none
// ============================================================================
// banco_registros_param: parametrised register bank, async reads with bypass
// Rev 1.0
// ============================================================================
module banco_registros_param
  import banco_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_READ*$clog2(DEPTH)-1:0] read_address,
  input  logic [$clog2(DEPTH)-1:0]          write_address,
  input  logic [WIDTH-1:0]                  data_write,
  input  logic                              write_enable,
  input  logic                              clear_req,
  output logic [NUM_READ*WIDTH-1:0]         data_register,
  output logic                              ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_ready;
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_addr;
  logic             w_bypass_ok;
  logic             w_user_we;

  // Out-of-range entries and the hardwired zero register never hold data.
  function automatic logic addr_valid(input logic [AW-1:0] a);
    return ({1'b0, a} < c_depth) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  banco_clear_fsm #(
    .DEPTH(DEPTH)
  ) u_clear_fsm (
    .clk        (clk),
    .rst        (rst),
    .i_clear_req(clear_req),
    .o_ready    (w_ready),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign w_bypass_ok = write_enable && !clear_req;
  assign w_user_we   = w_ready && !rst && w_bypass_ok && addr_valid(write_address);

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_user_we) begin
      r_mem[write_address] <= data_write;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_read
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_data;

    assign w_addr = read_address[p*AW +: AW];

    always_comb begin
      w_data = '0;
      if (w_ready && addr_valid(w_addr)) begin
        if (w_bypass_ok && (w_addr == write_address)) begin
          w_data = data_write;
        end else begin
          w_data = r_mem[w_addr];
        end
      end
    end

    assign data_register[p*WIDTH +: WIDTH] = w_data;
  end

  assign ready = w_ready;
endmodule
`default_nettype wire

// File: tb/tb_banco_registros_param.sv
`default_nettype none
// ============================================================================
// tb_banco_registros_param: bench for three bank configurations on shared stimulus
// Rev 1.0
// ============================================================================
module tb_banco_registros_param;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NV = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR*AW-1:0] read_address = '0;
  logic [AW-1:0]    write_address = '0;
  logic [W-1:0]     data_write = '0;
  logic             write_enable = 1'b0;
  logic             clear_req = 1'b0;
  logic [NR*W-1:0]  dr0, dr1, dr2;
  logic             rdy0, rdy1, rdy2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [W-1:0]  e0;
    logic [W-1:0]  e1;
    logic [W-1:0]  ez;
    logic [W-1:0]  e20;
  } vec_t;

  vec_t vecs [NV];
  vec_t sb [$];
  vec_t exp_v;

  always #5 clk = ~clk;

  banco_registros_param #(.WIDTH(32), .DEPTH(32), .NUM_READ(2), .ZERO_REG(1)) dut0 (
    .clk(clk), .rst(rst), .read_address(read_address), .write_address(write_address),
    .data_write(data_write), .write_enable(write_enable), .clear_req(clear_req),
    .data_register(dr0), .ready(rdy0)
  );

  banco_registros_param #(.WIDTH(32), .DEPTH(32), .NUM_READ(2), .ZERO_REG(0)) dut1 (
    .clk(clk), .rst(rst), .read_address(read_address), .write_address(write_address),
    .data_write(data_write), .write_enable(write_enable), .clear_req(clear_req),
    .data_register(dr1), .ready(rdy1)
  );

  banco_registros_param #(.WIDTH(32), .DEPTH(20), .NUM_READ(2), .ZERO_REG(1)) dut2 (
    .clk(clk), .rst(rst), .read_address(read_address), .write_address(write_address),
    .data_write(data_write), .write_enable(write_enable), .clear_req(clear_req),
    .data_register(dr2), .ready(rdy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    read_address = {a1, a0};
  endtask

  // Walks the DEPTH=32 sweep edge by edge; optionally injects a write and a clear_req mid-sweep.
  task automatic sweep(input string name, input bit extras);
    set_rd(5'd7, 5'd31);
    for (int i = 0; i < 32; i++) begin
      if (extras && i == 10) begin
        write_enable = 1'b1; write_address = 5'd3; data_write = 32'h77;
      end
      if (extras && i == 11) write_enable = 1'b0;
      if (extras && i == 20) clear_req = 1'b1;
      if (extras && i == 21) clear_req = 1'b0;
      @(negedge clk);
      chk($sformatf("%s ready_low[%0d]", name, i), {31'b0, rdy0}, 32'd0);
      chk($sformatf("%s p0_zero[%0d]", name, i), dr0[31:0], 32'd0);
      chk($sformatf("%s p1_zero[%0d]", name, i), dr0[63:32], 32'd0);
      if (i == 19) chk($sformatf("%s d20_ready_low", name), {31'b0, rdy2}, 32'd0);
      if (i == 20) chk($sformatf("%s d20_ready_high", name), {31'b0, rdy2}, 32'd1);
      @(posedge clk); #1;
    end
    chk({name, " ready_high"}, {31'b0, rdy0}, 32'd1);
    chk({name, " zr0_ready_high"}, {31'b0, rdy1}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          we    wa     wd             ra0    ra1    e0             e1             ez             e20
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h1234,     32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h1234,     32'h0};
    vecs[4] = '{1'b1, 5'd25, 32'hAA,       5'd25, 5'd5,  32'hAA,       32'hDEADBEEF, 32'hAA,       32'h0};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd25, 5'd19, 32'hAA,       32'h0,        32'hAA,       32'h0};
    vecs[6] = '{1'b1, 5'd19, 32'h55,       5'd19, 5'd25, 32'h55,       32'hAA,       32'h55,       32'h55};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd19, 5'd19, 32'h55,       32'h55,       32'h55,       32'h55};
    vecs[8] = '{1'b1, 5'd31, 32'hCAFE0000, 5'd31, 5'd30, 32'hCAFE0000, 32'h0,        32'hCAFE0000, 32'h0};

    set_rd(5'd5, 5'd5);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", {31'b0, rdy0}, 32'd0);
    chk("reset p0", dr0[31:0], 32'd0);
    chk("reset p1", dr0[63:32], 32'd0);
    rst = 1'b0;
    sweep("rst_sweep", 1'b0);

    for (int i = 0; i < NV; i++) begin
      write_enable  = vecs[i].we;
      write_address = vecs[i].wa;
      data_write    = vecs[i].wd;
      set_rd(vecs[i].ra0, vecs[i].ra1);
      sb.push_back(vecs[i]);
      @(negedge clk);
      exp_v = sb.pop_front();
      chk($sformatf("vec%0d p0", i), dr0[31:0], exp_v.e0);
      chk($sformatf("vec%0d p1", i), dr0[63:32], exp_v.e1);
      chk($sformatf("vec%0d zr0 p0", i), dr1[31:0], exp_v.ez);
      chk($sformatf("vec%0d d20 p0", i), dr2[31:0], exp_v.e20);
      @(posedge clk); #1;
    end
    write_enable = 1'b0;

    for (int i = 1; i < 32; i++) begin
      write_enable = 1'b1; write_address = AW'(i); data_write = 32'(i);
      @(posedge clk); #1;
    end
    write_enable = 1'b0;
    for (int i = 1; i < 32; i++) begin
      set_rd(AW'(i), AW'(32 - i));
      @(negedge clk);
      chk($sformatf("fill p0 r%0d", i), dr0[31:0], 32'(i));
      chk($sformatf("fill p1 r%0d", 32 - i), dr0[63:32], 32'(32 - i));
      @(posedge clk); #1;
    end

    // clear_req and a write on the same edge: no bypass, write dropped.
    set_rd(5'd7, 5'd7);
    clear_req = 1'b1; write_enable = 1'b1; write_address = 5'd7; data_write = 32'hFF;
    @(negedge clk);
    chk("clr edge no bypass", dr0[31:0], 32'd7);
    @(posedge clk); #1;
    clear_req = 1'b0; write_enable = 1'b0;
    sweep("clr_sweep", 1'b1);
    set_rd(5'd7, 5'd3);
    @(negedge clk);
    chk("after clr r7", dr0[31:0], 32'd0);
    chk("after clr r3", dr0[63:32], 32'd0);
    set_rd(5'd31, 5'd1);
    #1;
    chk("after clr r31", dr0[31:0], 32'd0);
    chk("after clr r1", dr0[63:32], 32'd0);
    @(posedge clk); #1;

    // rst lands when the sweep counter has reached 10.
    write_enable = 1'b1; write_address = 5'd9; data_write = 32'h99;
    @(posedge clk); #1;
    write_enable = 1'b0;
    set_rd(5'd9, 5'd9);
    @(negedge clk);
    chk("pre rst r9", dr0[31:0], 32'h99);
    @(posedge clk); #1;
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (9) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst ready", {31'b0, rdy0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sweep("rstmid_sweep", 1'b0);
    set_rd(5'd9, 5'd5);
    @(negedge clk);
    chk("after rstmid r9", dr0[31:0], 32'd0);
    chk("after rstmid r5", dr0[63:32], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
